// File: rtl/mp_add_pkg.sv
// ============================================================================
// Module      : mp_add_pkg
// Description : Shared types and defaults for the multi-precision add/sub
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mp_add_pkg;

  localparam int STATE_W   = 2;
  localparam int DEF_SIZE  = 8;
  localparam int DEF_WORDS = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ripple_adder.sv
// ============================================================================
// Module      : ripple_adder
// Description : size-bit ripple-carry adder built from a full-adder chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_adder #(
  parameter int size = 8
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            cin,
  output logic [size-1:0] s,
  output logic            cout
);

  logic [size:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < size; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[size];

endmodule

`default_nettype wire

// File: rtl/mp_add_seq.sv
// ============================================================================
// Module      : mp_add_seq
// Description : WORDS x SIZE-bit add/subtract, one word per clock through a
//               single SIZE-bit ripple adder, LSW first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [SIZE*WORDS-1:0] a,
  input  logic [SIZE*WORDS-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*WORDS-1:0] sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W    = SIZE * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] C_IDX_LAST = IDXW'(WORDS - 1);

  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    sum_q;
  logic [W-1:0]    sum_d;
  logic            amsb_q;
  logic            bmsb_q;
  logic            busy_q;
  logic            done_q;
  logic            cout_q;
  logic            ovf_q;

  logic [SIZE-1:0] w_add_s;
  logic            w_add_co;
  logic            w_ovf_d;

  ripple_adder #(.size(SIZE)) u_adder (
    .a    (opa_q[SIZE-1:0]),
    .b    (opb_q[SIZE-1:0]),
    .cin  (carry_q),
    .s    (w_add_s),
    .cout (w_add_co)
  );

  // Each new word enters at the top so the LSW lands at bit 0 after WORDS shifts.
  if (WORDS == 1) begin : g_one_word
    assign sum_d = w_add_s;
  end else begin : g_multi_word
    assign sum_d = {w_add_s, sum_q[W-1:SIZE]};
  end

  // Evaluated on the final word: w_add_s[SIZE-1] becomes sum[W-1].
  assign w_ovf_d = (amsb_q == bmsb_q) && (w_add_s[SIZE-1] != amsb_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          opa_q   <= opa_q >> SIZE;
          opb_q   <= opb_q >> SIZE;
          sum_q   <= sum_d;
          carry_q <= w_add_co;
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == C_IDX_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= w_add_co;
            ovf_q   <= w_ovf_d;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            amsb_q  <= a[W-1];
            bmsb_q  <= sub ? ~b[W-1] : b[W-1];
            carry_q <= sub;
            idx_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire
